// File: rtl/selector_pkg.sv
// selector_pkg: opcodes, width and the Brent-Kung (G,P) combine operator shared by the selector ALU
package selector_pkg;
    localparam int WIDTH = 4;
    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;
    // Pairs are packed as {g, p}; hi is the more significant span
    function automatic logic [1:0] gp_op(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction
endpackage

// File: rtl/half_adder.sv
// half_adder: per-bit generate/propagate leaf
module half_adder (
    input  logic a,
    input  logic b,
    output logic g,
    output logic p
);
    assign g = a & b;
    assign p = a ^ b;
endmodule

// File: rtl/sumador_bk.sv
// sumador_bk: 4-bit combinational Brent-Kung prefix adder
module sumador_bk import selector_pkg::*; (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       c
);
    logic [3:0] w_g, w_p;
    logic [1:0] w_gp10, w_gp32, w_gp30, w_gp20;
    logic [4:0] w_c;
    for (genvar i = 0; i < 4; i++) begin : g_ha
        half_adder u_ha (.a(a[i]), .b(b[i]), .g(w_g[i]), .p(w_p[i]));
    end
    assign w_gp10 = gp_op({w_g[1], w_p[1]}, {w_g[0], w_p[0]});
    assign w_gp32 = gp_op({w_g[3], w_p[3]}, {w_g[2], w_p[2]});
    assign w_gp30 = gp_op(w_gp32, w_gp10);
    // Down-sweep fills in the one span the up-sweep skips
    assign w_gp20 = gp_op({w_g[2], w_p[2]}, w_gp10);
    assign w_c = {w_gp30[1] | (w_gp30[0] & cin),
                  w_gp20[1] | (w_gp20[0] & cin),
                  w_gp10[1] | (w_gp10[0] & cin),
                  w_g[0] | (w_p[0] & cin),
                  cin};
    assign sum = w_p ^ w_c[3:0];
    assign c   = w_c[4];
endmodule

// File: rtl/selector.sv
// selector: registered 4-bit XOR/AND/ADD/SUB unit with one-cycle latency
module selector #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);
    import selector_pkg::*;
    logic [WIDTH-1:0] w_g, w_p, w_b, w_sum, w_res;
    logic             w_cin, w_cout, w_co;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ha
        half_adder u_ha (.a(a[i]), .b(b[i]), .g(w_g[i]), .p(w_p[i]));
    end
    // SUB reuses the adder as a + ~b + 1
    assign w_b   = (sel == OP_SUB) ? ~b : b;
    assign w_cin = (sel == OP_SUB) ? 1'b1 : cin;
    sumador_bk u_add (.a(a), .b(w_b), .cin(w_cin), .sum(w_sum), .c(w_cout));
    always_comb begin
        w_res = (sel == OP_XOR) ? w_p : (sel == OP_AND) ? w_g : w_sum;
        w_co  = (sel == OP_ADD || sel == OP_SUB) ? w_cout : 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            result    <= w_res;
            carry_out <= w_co;
        end
    end
endmodule

// File: tb/tb_selector.sv
// tb_selector: directed vector table, latency/reset sequences and exhaustive sweep for selector
module tb_selector;
    typedef struct {
        logic [1:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] r;
        logic       c;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] result;
    logic       carry_out;
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[12];

    selector #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sel(sel),
        .result(result), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] model(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y, input logic ci);
        return (s == 2'b00) ? {1'b0, x ^ y} :
               (s == 2'b01) ? {1'b0, x & y} :
               (s == 2'b10) ? ({1'b0, x} + {1'b0, y} + {4'b0, ci}) :
                              {x >= y, 4'(x - y)};
    endfunction

    task automatic check(input string name, input logic [3:0] er, input logic ec);
        checks++;
        if (result !== er || carry_out !== ec) begin
            errors++;
            $display("FAIL %s: got result=%b carry=%b expected result=%b carry=%b", name, result, carry_out, er, ec);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y, input logic ci);
        @(negedge clk);
        sel = s; a = x; b = y; cin = ci;
    endtask

    task automatic edge_sample;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 4'b1010, 4'b1100, 1'b0, 4'b0110, 1'b0};
        vecs[1]  = '{2'b01, 4'b1010, 4'b1100, 1'b0, 4'b1000, 1'b0};
        vecs[2]  = '{2'b10, 4'b0111, 4'b1111, 1'b0, 4'b0110, 1'b1};
        vecs[3]  = '{2'b10, 4'b1111, 4'b1100, 1'b1, 4'b1100, 1'b1};
        vecs[4]  = '{2'b10, 4'b0000, 4'b0110, 1'b0, 4'b0110, 1'b0};
        vecs[5]  = '{2'b11, 4'b0111, 4'b0001, 1'b0, 4'b0110, 1'b1};
        vecs[6]  = '{2'b11, 4'b0001, 4'b0010, 1'b0, 4'b1111, 1'b0};
        vecs[7]  = '{2'b11, 4'b0000, 4'b1001, 1'b0, 4'b0111, 1'b0};
        vecs[8]  = '{2'b11, 4'b1111, 4'b0011, 1'b1, 4'b1100, 1'b1};
        vecs[9]  = '{2'b10, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1};
        vecs[10] = '{2'b11, 4'b0101, 4'b0101, 1'b1, 4'b0000, 1'b1};
        vecs[11] = '{2'b00, 4'b1111, 4'b0101, 1'b1, 4'b1010, 1'b0};

        sel = 2'b10; a = 4'b1111; b = 4'b1111; cin = 1'b1;
        #1;
        check("reset_async", 4'b0000, 1'b0);
        edge_sample();
        check("reset_hold_edge", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        check("first_after_reset", 4'b1111, 1'b1);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin);
            edge_sample();
            check($sformatf("vec%0d", i), vecs[i].r, vecs[i].c);
        end

        drive(2'b10, 4'b0111, 4'b1111, 1'b0);
        edge_sample();
        check("lat_first", 4'b0110, 1'b1);
        drive(2'b01, 4'b1010, 4'b1100, 1'b0);
        #1;
        check("lat_no_comb", 4'b0110, 1'b1);
        edge_sample();
        check("lat_next_edge", 4'b1000, 1'b0);

        drive(2'b11, 4'b0001, 4'b0010, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_async", 4'b0000, 1'b0);
        edge_sample();
        check("midrst_hold", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sel = 2'b10; a = 4'b0011; b = 4'b0100; cin = 1'b1;
        edge_sample();
        check("midrst_release", 4'b1000, 1'b0);

        for (int s = 0; s < 4; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    for (int ci = 0; ci < 2; ci++) begin
                        logic [4:0] e;
                        e = model(2'(s), 4'(x), 4'(y), 1'(ci));
                        drive(2'(s), 4'(x), 4'(y), 1'(ci));
                        edge_sample();
                        check($sformatf("exh s=%0d a=%0d b=%0d cin=%0d", s, x, y, ci), e[3:0], e[4]);
                    end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
